// File: rtl/led_seq_ctrl.sv
// LED sequencer: start/stop/hold controller stepping a 10-LED pattern once per TICK_DIV cycles.
// All outputs are registered, so they change one clock after the inputs that cause them.
module led_seq_ctrl #(
  parameter int TICK_DIV = 25000000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       stop,
  input  logic       hold,
  input  logic [1:0] mode,
  output logic [9:0] LEDR,
  output logic [3:0] CurrentState,
  output logic       busy,
  output logic       done
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [4:0]    step;
  logic [PW-1:0] presc;
  logic [1:0]    mode_q;

  logic          tick;
  logic          at_last;
  logic [4:0]    step_inc;

  // Bounce walks 0..9 and back down to 0, so its position folds past step 9.
  function automatic logic [3:0] pos(input logic [1:0] m, input logic [4:0] s);
    if (m == 2'b10 && s > 5'd9) return 4'(5'd18 - s);
    return s[3:0];
  endfunction

  function automatic logic [9:0] pattern(input logic [1:0] m, input logic [3:0] p);
    case (m)
      2'b00:        return 10'h200 >> p;
      2'b01, 2'b10: return 10'h001 << p;
      default:      return 10'h3FF << (4'd9 - p);
    endcase
  endfunction

  assign tick     = (presc == PW'(TICK_DIV - 1));
  assign at_last  = (step == ((mode_q == 2'b10) ? 5'd18 : 5'd9));
  assign step_inc = step + 5'd1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      step         <= 5'd0;
      presc        <= '0;
      mode_q       <= 2'b00;
      LEDR         <= 10'd0;
      CurrentState <= 4'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state        <= RUN;
            step         <= 5'd0;
            presc        <= '0;
            mode_q       <= mode;
            LEDR         <= pattern(mode, pos(mode, 5'd0));
            CurrentState <= pos(mode, 5'd0);
            busy         <= 1'b1;
          end
        end
        RUN: begin
          // Stop wins over hold and over a completing tick: it is always an abort.
          if (stop) begin
            state        <= IDLE;
            step         <= 5'd0;
            presc        <= '0;
            LEDR         <= 10'd0;
            CurrentState <= 4'd0;
            busy         <= 1'b0;
          end else if (!hold) begin
            if (tick) begin
              presc <= '0;
              if (at_last) begin
                state        <= IDLE;
                step         <= 5'd0;
                LEDR         <= 10'd0;
                CurrentState <= 4'd0;
                busy         <= 1'b0;
                done         <= 1'b1;
              end else begin
                step         <= step_inc;
                LEDR         <= pattern(mode_q, pos(mode_q, step_inc));
                CurrentState <= pos(mode_q, step_inc);
              end
            end else begin
              presc <= presc + PW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with TICK_DIV=4: expected outputs are queued per cycle and checked after each edge.
module tb_led_seq_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start;
  logic       stop;
  logic       hold;
  logic [1:0] mode;
  logic [9:0] LEDR;
  logic [3:0] CurrentState;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  led_seq_ctrl #(.TICK_DIV(4)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop), .hold(hold),
    .mode(mode), .LEDR(LEDR), .CurrentState(CurrentState), .busy(busy), .done(done)
  );

  always #10 clock = ~clock;

  function automatic logic [3:0] exp_p(input logic [1:0] m, input int s);
    int v;
    v = (m == 2'b10 && s > 9) ? 18 - s : s;
    return v[3:0];
  endfunction

  function automatic logic [9:0] exp_led(input logic [1:0] m, input logic [3:0] p);
    logic [9:0] all_on;
    all_on = 10'h3FF;
    case (m)
      2'b00:   return 10'h200 >> p;
      2'b01:   return 10'h001 << p;
      2'b10:   return 10'h001 << p;
      default: return ~(all_on >> (p + 1));
    endcase
  endfunction

  task automatic push(input logic [9:0] led, input logic [3:0] cs, input logic b, input logic d);
    exp_q.push_back({led, cs, b, d});
  endtask

  task automatic check_now(input string tag);
    logic [15:0] e;
    logic [15:0] obs;
    obs = {LEDR, CurrentState, busy, done};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s: no expectation queued, observed=%h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s: observed led=%h cs=%0d busy=%b done=%b expected led=%h cs=%0d busy=%b done=%b",
               tag, obs[15:6], obs[5:2], obs[1], obs[0], e[15:6], e[5:2], e[1], e[0]);
      end
    end
  endtask

  task automatic cyc(input string tag);
    @(posedge clock);
    #1;
    check_now(tag);
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      push(10'd0, 4'd0, 1'b0, 1'b0);
      cyc(tag);
    end
  endtask

  // One run from a start pulse; optional hold inside one step, stop inside one step, and mid-run mode/start noise.
  task automatic run(input logic [1:0] m, input int hold_s, input int hold_n,
                     input int stop_s, input bit noise, input string tag);
    int  last;
    int  dur;
    bit  aborted;
    last    = (m == 2'b10) ? 18 : 9;
    aborted = 1'b0;
    mode  = m;
    start = 1'b1;
    push(exp_led(m, exp_p(m, 0)), exp_p(m, 0), 1'b1, 1'b0);
    cyc(tag);
    start = 1'b0;
    if (noise) mode = 2'b00;
    for (int s = 0; s <= last && !aborted; s++) begin
      dur = 4 + ((s == hold_s) ? hold_n : 0);
      for (int c = (s == 0) ? 1 : 0; c < dur && !aborted; c++) begin
        hold  = (s == hold_s && c >= 1 && c <= hold_n);
        start = (noise && s == 4 && c == 1);
        if (s == stop_s && c == 2) begin
          stop = 1'b1;
          push(10'd0, 4'd0, 1'b0, 1'b0);
          cyc({tag, "_stop"});
          stop    = 1'b0;
          aborted = 1'b1;
        end else begin
          push(exp_led(m, exp_p(m, s)), exp_p(m, s), 1'b1, 1'b0);
          cyc(tag);
        end
      end
    end
    hold  = 1'b0;
    start = 1'b0;
    if (!aborted) begin
      push(10'd0, 4'd0, 1'b0, 1'b1);
      cyc({tag, "_done"});
    end
    idle_cycles(2, {tag, "_idle"});
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b1;
    stop    = 1'b0;
    hold    = 1'b0;
    mode    = 2'b11;
    #3;
    push(10'd0, 4'd0, 1'b0, 1'b0);
    check_now("reset_t0");
    idle_cycles(3, "in_reset");
    reset_n = 1'b1;
    start   = 1'b0;
    idle_cycles(2, "post_reset");

    run(2'b00, -1, 0, -1, 1'b0, "sweep_right");
    run(2'b10, -1, 0, -1, 1'b0, "bounce");
    run(2'b11, -1, 0, -1, 1'b1, "fill_mode_change");
    run(2'b00, 3, 10, -1, 1'b0, "hold_step3");
    run(2'b01, -1, 0, 5, 1'b0, "stop_step5");

    start = 1'b1;
    stop  = 1'b1;
    mode  = 2'b00;
    idle_cycles(1, "start_with_stop");
    start = 1'b0;
    stop  = 1'b0;
    idle_cycles(2, "start_with_stop_after");

    // Reset asserted between edges while running: outputs must clear without a clock edge.
    mode  = 2'b00;
    start = 1'b1;
    push(10'h200, 4'd0, 1'b1, 1'b0);
    cyc("pre_reset_run");
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push((i < 3) ? 10'h200 : 10'h100, (i < 3) ? 4'd0 : 4'd1, 1'b1, 1'b0);
      cyc("pre_reset_run");
    end
    #4;
    reset_n = 1'b0;
    #2;
    push(10'd0, 4'd0, 1'b0, 1'b0);
    check_now("async_reset");
    idle_cycles(2, "held_in_reset");
    reset_n = 1'b1;
    idle_cycles(2, "after_release");
    run(2'b00, -1, 0, -1, 1'b0, "restart");

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL queue_drain: observed %0d leftover expected entries, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
